pmem_write_buffer: RTL and testbench

- Single-line write-back buffer between the cache system's burst port (cacheline adaptor side) and physical memory.
- A dirty-line write burst is absorbed locally in 4 cycles, so the cache system can continue immediately.
- Misses to other lines bypass the buffer, and reads of the buffered line are served from the buffer.
- The buffered line drains to memory when the upstream port is idle, or before a conflicting write is accepted.

---
 rtl/pmem_write_buffer_pkg.sv | 16 +
 rtl/pmem_write_buffer_if.sv | 20 ++
 rtl/pmem_write_buffer_line.sv | 27 ++
 rtl/pmem_write_buffer.sv | 144 ++++++++++++++
 tb/tb_pmem_write_buffer.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pmem_write_buffer_pkg.sv
// Shared types and constants for the physical-memory write buffer.
//   pmem_wb_state_t   : buffer FSM state encoding
//   PMEM_LINE_OFFSET  : byte-offset bits of a cache line address
//   PMEM_BURST_BEATS  : beats per line burst
package rv32i_types;
   localparam int PMEM_LINE_OFFSET = 5;
   localparam int PMEM_BURST_BEATS = 4;

   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      HIT_READ,
      FWD_READ,
      DRAIN
   } pmem_wb_state_t;
endpackage

// File: rtl/pmem_write_buffer_if.sv
// Line-burst bus used on both sides of the write buffer.
//   read, write : burst request, held until the final resp
//   address     : line-aligned address
//   wdata       : write beat (requester -> responder)
//   rdata       : read beat (responder -> requester), valid with resp
//   resp        : one pulse per beat
// master drives the request side, slave drives rdata/resp.
interface pmem_write_buffer_if #(
   parameter int BEAT_W = 64
);
   logic              read;
   logic              write;
   logic [31:0]       address;
   logic [BEAT_W-1:0] wdata;
   logic [BEAT_W-1:0] rdata;
   logic              resp;

   modport master (output read, write, address, wdata, input rdata, resp);
   modport slave  (input read, write, address, wdata, output rdata, resp);
endinterface

// File: rtl/pmem_write_buffer_line.sv
// Storage for the single buffered line.
//   clk   : system clock
//   we    : write the beat at idx on the rising edge
//   idx   : beat index, also selects the read beat
//   wdata : beat to store
//   rdata : stored beat at idx (combinational)
module pmem_wb_line
   import rv32i_types::*;
#(
   parameter int BEAT_W = 64,
   parameter int BEATS  = PMEM_BURST_BEATS,
   localparam int IDX_W = $clog2(BEATS)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [BEAT_W-1:0] wdata,
   output logic [BEAT_W-1:0] rdata
);
   logic [BEAT_W-1:0] line_q [BEATS];

   always_ff @(posedge clk) begin
      if (we) line_q[idx] <= wdata;
   end

   assign rdata = line_q[idx];
endmodule

// File: rtl/pmem_write_buffer.sv
// Single-line write-back buffer between the cache burst port and memory.
// A dirty-line write is absorbed locally in BEATS cycles; the line drains
// to memory when upstream is idle or before a conflicting write.
//   clk, reset_n : system clock, asynchronous active-low reset
//   up           : slave side of the cache system burst port
//   mem          : master side towards physical memory
// Build option PMEM_WB_FORWARD_EN: read hits are served from the buffer.
// Without it a read hit drains the line first and then reads memory.
//
// state    | meaning
// IDLE     | arbitrate requests, start drain when idle and valid
// CAPTURE  | absorb one write beat per cycle into the buffer
// HIT_READ | return buffered beats upstream (forward build only)
// FWD_READ | pass a read burst straight through to memory
// DRAIN    | write the buffered line back to memory
module pmem_write_buffer
   import rv32i_types::*;
#(
   parameter int BEAT_W = 64,
   parameter int BEATS  = PMEM_BURST_BEATS
) (
   input  logic                  clk,
   input  logic                  reset_n,
   pmem_write_buffer_if.slave    up,
   pmem_write_buffer_if.master   mem
);
   localparam int CNT_W = $clog2(BEATS);
   localparam int TAG_W = 32 - PMEM_LINE_OFFSET;

   pmem_wb_state_t    state;
   logic [CNT_W-1:0]  count;
   logic [TAG_W-1:0]  buf_tag;
   logic              buf_valid;
   logic              hit;
   logic              last_beat;
   logic              line_we;
   logic [BEAT_W-1:0] line_rdata;
   logic              unused_addr_offset;

   assign hit       = buf_valid && (up.address[31:PMEM_LINE_OFFSET] == buf_tag);
   assign last_beat = (count == CNT_W'(BEATS - 1));
   assign unused_addr_offset = ^up.address[PMEM_LINE_OFFSET-1:0];

   pmem_wb_line #(.BEAT_W(BEAT_W), .BEATS(BEATS)) u_line (
      .clk   (clk),
      .we    (line_we),
      .idx   (count),
      .wdata (up.wdata),
      .rdata (line_rdata)
   );

   // count wraps to zero on the last beat, so every return to IDLE sees 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         count     <= '0;
         buf_tag   <= '0;
         buf_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               count <= '0;
               if (up.read && hit) begin
`ifdef PMEM_WB_FORWARD_EN
                  state <= HIT_READ;
`else
                  state <= DRAIN;
`endif
               end else if (up.read) begin
                  state <= FWD_READ;
               end else if (up.write && (!buf_valid || hit)) begin
                  state   <= CAPTURE;
                  buf_tag <= up.address[31:PMEM_LINE_OFFSET];
               end else if (up.write || buf_valid) begin
                  // conflicting write or idle upstream: write back first
                  state <= DRAIN;
               end
            end
            CAPTURE: begin
               count <= count + 1'b1;
               if (last_beat) begin
                  buf_valid <= 1'b1;
                  state     <= IDLE;
               end
            end
`ifdef PMEM_WB_FORWARD_EN
            HIT_READ: begin
               count <= count + 1'b1;
               if (last_beat) state <= IDLE;
            end
`endif
            FWD_READ: begin
               if (mem.resp) begin
                  count <= count + 1'b1;
                  if (last_beat) state <= IDLE;
               end
            end
            DRAIN: begin
               if (mem.resp) begin
                  count <= count + 1'b1;
                  if (last_beat) begin
                     buf_valid <= 1'b0;
                     state     <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decoded from the registered state; the read miss path is a
   // zero-latency pass-through of the memory beat.
   always_comb begin
      up.resp     = 1'b0;
      up.rdata    = '0;
      mem.read    = 1'b0;
      mem.write   = 1'b0;
      mem.address = '0;
      mem.wdata   = line_rdata;
      line_we     = 1'b0;
      case (state)
         CAPTURE: begin
            up.resp = 1'b1;
            line_we = 1'b1;
         end
         HIT_READ: begin
            up.resp  = 1'b1;
            up.rdata = line_rdata;
         end
         FWD_READ: begin
            mem.read    = 1'b1;
            mem.address = {up.address[31:PMEM_LINE_OFFSET], {PMEM_LINE_OFFSET{1'b0}}};
            up.rdata    = mem.rdata;
            up.resp     = mem.resp;
         end
         DRAIN: begin
            mem.write   = 1'b1;
            mem.address = {buf_tag, {PMEM_LINE_OFFSET{1'b0}}};
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_pmem_write_buffer.sv
module tb_pmem_write_buffer;
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   pmem_write_buffer_if #(.BEAT_W(64)) up_bus ();
   pmem_write_buffer_if #(.BEAT_W(64)) mem_bus ();

   pmem_write_buffer #(.BEAT_W(64), .BEATS(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .up      (up_bus),
      .mem     (mem_bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // memory model: lat idle cycles before each beat's resp pulse
   int          lat = 1;
   logic        m_resp;
   logic [1:0]  m_beat;
   int          m_cnt;
   logic [63:0] m_rdata;
   logic [28:0] m_key;
   logic [63:0] store [logic [28:0]];
   logic [95:0] wr_log [$];

   assign mem_bus.resp  = m_resp;
   assign mem_bus.rdata = m_rdata;
   assign m_key = {mem_bus.address[31:5], m_beat};

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_resp <= 1'b0; m_cnt <= 0; m_beat <= 2'd0; m_rdata <= '0;
      end else if (!(mem_bus.read || mem_bus.write)) begin
         m_resp <= 1'b0; m_cnt <= 0; m_beat <= 2'd0; m_rdata <= '0;
      end else if (m_resp) begin
         m_resp <= 1'b0; m_cnt <= 0; m_beat <= m_beat + 2'd1; m_rdata <= '0;
      end else if (m_cnt >= lat - 1) begin
         m_resp <= 1'b1;
         if (mem_bus.read) m_rdata <= store.exists(m_key) ? store[m_key] : 64'hDEAD_BEEF_DEAD_BEEF;
      end else begin
         m_cnt <= m_cnt + 1;
      end
   end

   // write-beat monitor: stores drained data and logs it in order
   initial begin
      forever begin
         @(negedge clk);
         if (reset_n && m_resp && mem_bus.write) begin
            store[m_key] = mem_bus.wdata;
            wr_log.push_back({mem_bus.address, mem_bus.wdata});
         end
      end
   end

   // Drives one upstream burst from the start of cycle 0 and records what
   // was observed; cycles are counted from the request cycle.
   task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [255:0] wline,
                         output logic [255:0] rline, output int first_c, output int last_c,
                         output int fwd_bad, output int drain_resp, output bit saw_mrd,
                         output bit saw_mwr, output logic [31:0] mrd_addr,
                         output int wlog_first, output bit tmo);
      int c;
      int beat;
      bit got;
      c = 0; beat = 0;
      rline = '0; first_c = -1; last_c = -1; fwd_bad = 0; drain_resp = 0;
      saw_mrd = 1'b0; saw_mwr = 1'b0; mrd_addr = '0; wlog_first = -1; tmo = 1'b0;
      up_bus.read    = !wr;
      up_bus.write   = wr;
      up_bus.address = addr;
      up_bus.wdata   = wline[63:0];
      while (beat < 4 && !tmo) begin
         @(negedge clk);
         got = up_bus.resp;
         if (mem_bus.read) begin
            saw_mrd  = 1'b1;
            mrd_addr = mem_bus.address;
            if (up_bus.resp !== mem_bus.resp) fwd_bad++;
         end
         if (mem_bus.write) begin
            saw_mwr = 1'b1;
            if (up_bus.resp) drain_resp++;
         end
         if (got) begin
            rline[beat*64 +: 64] = up_bus.rdata;
            if (beat == 0) begin
               first_c    = c;
               wlog_first = wr_log.size();
            end
            last_c = c;
         end
         @(posedge clk); #1;
         c++;
         if (got) begin
            beat++;
            if (beat < 4) up_bus.wdata = wline[beat*64 +: 64];
         end
         if (c > 400) tmo = 1'b1;
      end
      up_bus.read  = 1'b0;
      up_bus.write = 1'b0;
   endtask

   task automatic wait_idle(output bit tmo);
      int c;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while ((mem_bus.write || mem_bus.read || dut.buf_valid) && c < 500);
      tmo = (c >= 500);
      @(posedge clk); #1;
   endtask

   logic [255:0] rl, wl, exp_l, exp_l2;
   int fc, lc, fb, dr, wf;
   bit smr, smw, to;
   logic [31:0] ma;

   task automatic test_reset();
      reset_n = 1'b1;
      up_bus.read = 1'b0; up_bus.write = 1'b0; up_bus.address = '0; up_bus.wdata = '0;
      #2 reset_n = 1'b0;
      @(negedge clk);
      n_tests++; if (up_bus.resp !== 1'b0) begin n_fail++; $display("FAIL rst_up_resp: got %b want 0", up_bus.resp); end
      n_tests++; if (mem_bus.read !== 1'b0) begin n_fail++; $display("FAIL rst_mem_read: got %b want 0", mem_bus.read); end
      n_tests++; if (mem_bus.write !== 1'b0) begin n_fail++; $display("FAIL rst_mem_write: got %b want 0", mem_bus.write); end
      n_tests++; if (mem_bus.address !== 32'h0) begin n_fail++; $display("FAIL rst_mem_address: got %h want 0", mem_bus.address); end
      n_tests++; if (up_bus.rdata !== 64'h0) begin n_fail++; $display("FAIL rst_up_rdata: got %h want 0", up_bus.rdata); end
      n_tests++; if (dut.buf_valid !== 1'b0) begin n_fail++; $display("FAIL rst_buf_valid: got %b want 0", dut.buf_valid); end
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++; if (mem_bus.write !== 1'b0) begin n_fail++; $display("FAIL idle_no_drain: got %b want 0", mem_bus.write); end
      @(posedge clk); #1;
   endtask

   task automatic test_read_miss();
      logic [31:0] a;
      a = 32'h0000_1040;
      store[{a[31:5], 2'd0}] = 64'h11;
      store[{a[31:5], 2'd1}] = 64'h22;
      store[{a[31:5], 2'd2}] = 64'h33;
      store[{a[31:5], 2'd3}] = 64'h44;
      lat = 1; wr_log.delete();
      do_txn(1'b0, a, '0, rl, fc, lc, fb, dr, smr, smw, ma, wf, to);
      exp_l = {64'h44, 64'h33, 64'h22, 64'h11};
      n_tests++; if (to) begin n_fail++; $display("FAIL miss_timeout: got 1 want 0"); end
      n_tests++; if (rl !== exp_l) begin n_fail++; $display("FAIL miss_rdata: got %h want %h", rl, exp_l); end
      n_tests++; if (fb !== 0) begin n_fail++; $display("FAIL miss_resp_align: got %0d bad cycles want 0", fb); end
      n_tests++; if (ma !== 32'h0000_1040) begin n_fail++; $display("FAIL miss_mem_address: got %h want 00001040", ma); end
      n_tests++; if (smw !== 1'b0) begin n_fail++; $display("FAIL miss_no_write: got %b want 0", smw); end
   endtask

   task automatic test_write_drain();
      bit m5, m6, bv_last, bv_after, mw_after;
      logic [31:0] a6;
      int nresp, c;
      lat = 1; wr_log.delete();
      wl = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
      do_txn(1'b1, 32'h0000_2000, wl, rl, fc, lc, fb, dr, smr, smw, ma, wf, to);
      n_tests++; if (fc !== 1) begin n_fail++; $display("FAIL wr_first_resp: got %0d want 1", fc); end
      n_tests++; if (lc !== 4) begin n_fail++; $display("FAIL wr_last_resp: got %0d want 4", lc); end
      @(negedge clk); m5 = mem_bus.write;
      @(negedge clk); m6 = mem_bus.write; a6 = mem_bus.address;
      n_tests++; if (m5 !== 1'b0) begin n_fail++; $display("FAIL wr_cycle5_mem_write: got %b want 0", m5); end
      n_tests++; if (m6 !== 1'b1) begin n_fail++; $display("FAIL wr_cycle6_mem_write: got %b want 1", m6); end
      n_tests++; if (a6 !== 32'h0000_2000) begin n_fail++; $display("FAIL wr_drain_address: got %h want 00002000", a6); end
      nresp = 0; c = 0; bv_last = 1'b0;
      while (nresp < 4 && c < 200) begin
         @(negedge clk); c++;
         if (mem_bus.write && mem_bus.resp) begin
            nresp++;
            if (nresp == 4) bv_last = dut.buf_valid;
         end
      end
      @(negedge clk); bv_after = dut.buf_valid; mw_after = mem_bus.write;
      @(posedge clk); #1;
      n_tests++; if (nresp !== 4) begin n_fail++; $display("FAIL wr_drain_beats: got %0d want 4", nresp); end
      n_tests++; if (bv_last !== 1'b1) begin n_fail++; $display("FAIL wr_valid_at_last: got %b want 1", bv_last); end
      n_tests++; if (bv_after !== 1'b0) begin n_fail++; $display("FAIL wr_valid_cleared: got %b want 0", bv_after); end
      n_tests++; if (mw_after !== 1'b0) begin n_fail++; $display("FAIL wr_drain_ends: got %b want 0", mw_after); end
      n_tests++; if (wr_log.size() !== 4) begin n_fail++; $display("FAIL wr_log_size: got %0d want 4", wr_log.size()); end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (((i < wr_log.size()) ? wr_log[i] : 96'h0) !== {32'h0000_2000, wl[i*64 +: 64]}) begin
            n_fail++;
            $display("FAIL wr_drain_beat%0d: got %h want %h", i, (i < wr_log.size()) ? wr_log[i] : 96'h0, {32'h0000_2000, wl[i*64 +: 64]});
         end
      end
   endtask

   task automatic test_write_read_same();
      lat = 20; wr_log.delete();
      // read arrives while the drain is already running
      wl = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
      do_txn(1'b1, 32'h0000_2000, wl, rl, fc, lc, fb, dr, smr, smw, ma, wf, to);
      @(posedge clk); #1;
      do_txn(1'b0, 32'h0000_2000, '0, rl, fc, lc, fb, dr, smr, smw, ma, wf, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL wrs_timeout: got 1 want 0"); end
      n_tests++; if (rl !== wl) begin n_fail++; $display("FAIL wrs_rdata: got %h want %h", rl, wl); end
      n_tests++; if (smw !== 1'b1) begin n_fail++; $display("FAIL wrs_drain_seen: got %b want 1", smw); end
      n_tests++; if (dr !== 0) begin n_fail++; $display("FAIL wrs_resp_in_drain: got %0d want 0", dr); end
      n_tests++; if (wf !== 4) begin n_fail++; $display("FAIL wrs_drain_first: got %0d want 4", wf); end
      n_tests++; if (smr !== 1'b1) begin n_fail++; $display("FAIL wrs_mem_read: got %b want 1", smr); end
      n_tests++; if (fb !== 0) begin n_fail++; $display("FAIL wrs_resp_align: got %0d want 0", fb); end
      wait_idle(to);
      // read presented in the first IDLE cycle after capture
      wr_log.delete();
      wl = {64'hE3, 64'hE2, 64'hE1, 64'hE0};
      do_txn(1'b1, 32'h0000_2000, wl, rl, fc, lc, fb, dr, smr, smw, ma, wf, to);
      do_txn(1'b0, 32'h0000_2000, '0, rl, fc, lc, fb, dr, smr, smw, ma, wf, to);
      n_tests++; if (rl !== wl) begin n_fail++; $display("FAIL hit_rdata: got %h want %h", rl, wl); end
`ifdef PMEM_WB_FORWARD_EN
      n_tests++; if (smr !== 1'b0) begin n_fail++; $display("FAIL hit_no_mem_read: got %b want 0", smr); end
      n_tests++; if (smw !== 1'b0) begin n_fail++; $display("FAIL hit_no_mem_write: got %b want 0", smw); end
      n_tests++; if (fc !== 1) begin n_fail++; $display("FAIL hit_first_resp: got %0d want 1", fc); end
      n_tests++; if (lc !== 4) begin n_fail++; $display("FAIL hit_last_resp: got %0d want 4", lc); end
`else
      n_tests++; if (smw !== 1'b1) begin n_fail++; $display("FAIL hit_drain_seen: got %b want 1", smw); end
      n_tests++; if (smr !== 1'b1) begin n_fail++; $display("FAIL hit_mem_read: got %b want 1", smr); end
      n_tests++; if (wf !== 4) begin n_fail++; $display("FAIL hit_drain_first: got %0d want 4", wf); end
      n_tests++; if (dr !== 0) begin n_fail++; $display("FAIL hit_resp_in_drain: got %0d want 0", dr); end
`endif
      wait_idle(to);
      n_tests++; if (to) begin n_fail++; $display("FAIL hit_idle_timeout: got 1 want 0"); end
   endtask

   task automatic test_conflict_write();
      lat = 2; wr_log.delete();
      exp_l  = {64'hF3, 64'hF2, 64'hF1, 64'hF0};
      exp_l2 = {64'h43, 64'h42, 64'h41, 64'h40};
      do_txn(1'b1, 32'h0000_3000, exp_l, rl, fc, lc, fb, dr, smr, smw, ma, wf, to);
      do_txn(1'b1, 32'h0000_4000, exp_l2, rl, fc, lc, fb, dr, smr, smw, ma, wf, to);
      n_tests++; if (wf !== 4) begin n_fail++; $display("FAIL cw_drain_before_capture: got %0d want 4", wf); end
      n_tests++; if (dr !== 0) begin n_fail++; $display("FAIL cw_resp_in_drain: got %0d want 0", dr); end
      wait_idle(to);
      n_tests++; if (wr_log.size() !== 8) begin n_fail++; $display("FAIL cw_log_size: got %0d want 8", wr_log.size()); end
      for (int i = 0; i < 8; i++) begin
         logic [95:0] e;
         e = (i < 4) ? {32'h0000_3000, exp_l[i*64 +: 64]} : {32'h0000_4000, exp_l2[(i-4)*64 +: 64]};
         n_tests++;
         if (((i < wr_log.size()) ? wr_log[i] : 96'h0) !== e) begin
            n_fail++;
            $display("FAIL cw_beat%0d: got %h want %h", i, (i < wr_log.size()) ? wr_log[i] : 96'h0, e);
         end
      end
   endtask

   task automatic test_write_hit();
      lat = 1; wr_log.delete();
      wl    = {64'hB3, 64'hB2, 64'hB1, 64'hB0};
      exp_l = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
      do_txn(1'b1, 32'h0000_5000, wl, rl, fc, lc, fb, dr, smr, smw, ma, wf, to);
      do_txn(1'b1, 32'h0000_5000, exp_l, rl, fc, lc, fb, dr, smr, smw, ma, wf, to);
      n_tests++; if (fc !== 1) begin n_fail++; $display("FAIL wh_first_resp: got %0d want 1", fc); end
      n_tests++; if (smw !== 1'b0) begin n_fail++; $display("FAIL wh_no_drain: got %b want 0", smw); end
      wait_idle(to);
      n_tests++; if (wr_log.size() !== 4) begin n_fail++; $display("FAIL wh_log_size: got %0d want 4", wr_log.size()); end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (((i < wr_log.size()) ? wr_log[i] : 96'h0) !== {32'h0000_5000, exp_l[i*64 +: 64]}) begin
            n_fail++;
            $display("FAIL wh_beat%0d: got %h want %h", i, (i < wr_log.size()) ? wr_log[i] : 96'h0, {32'h0000_5000, exp_l[i*64 +: 64]});
         end
      end
   endtask

   task automatic test_reset_mid_drain();
      int c;
      int seen_wr;
      lat = 3; wr_log.delete();
      wl = {64'h63, 64'h62, 64'h61, 64'h60};
      do_txn(1'b1, 32'h0000_6000, wl, rl, fc, lc, fb, dr, smr, smw, ma, wf, to);
      c = 0;
      while (wr_log.size() < 2 && c < 100) begin
         @(negedge clk); #1; c++;
      end
      @(posedge clk); #2;
      n_tests++; if (mem_bus.write !== 1'b1) begin n_fail++; $display("FAIL rmd_in_drain: got %b want 1", mem_bus.write); end
      reset_n = 1'b0;
      #1;
      n_tests++; if (mem_bus.write !== 1'b0) begin n_fail++; $display("FAIL rmd_mem_write: got %b want 0", mem_bus.write); end
      n_tests++; if (dut.buf_valid !== 1'b0) begin n_fail++; $display("FAIL rmd_buf_valid: got %b want 0", dut.buf_valid); end
      @(posedge clk); #1 reset_n = 1'b1;
      seen_wr = 0;
      repeat (20) begin
         @(negedge clk);
         if (mem_bus.write) seen_wr++;
      end
      @(posedge clk); #1;
      n_tests++; if (seen_wr !== 0) begin n_fail++; $display("FAIL rmd_no_drain: got %0d cycles want 0", seen_wr); end
      n_tests++; if (wr_log.size() !== 2) begin n_fail++; $display("FAIL rmd_log_size: got %0d want 2", wr_log.size()); end
   endtask

   initial begin
      test_reset();
      test_read_miss();
      test_write_drain();
      test_write_read_same();
      test_conflict_write();
      test_write_hit();
      test_reset_mid_drain();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
